// File: rtl/mem_stage_lsu.sv
// Load/store unit for the MEM stage: issues data-bus requests, formats load data,
// and stalls the upstream pipeline while an access is outstanding.
//   state      | meaning
//   IDLE       | no access outstanding; request driven straight from EX/MEM
//   WAIT_GNT   | request issued, waiting for the bus to accept it
//   WAIT_RDATA | load accepted, waiting for read data
module mem_stage_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] read_data_o,
  output logic [31:0] alu_res_o,
  output logic [4:0]  rd_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_GNT   = 2'd1;
  localparam logic [1:0] S_WAIT_RDATA = 2'd2;
  localparam logic [7:0] TIMEOUT_CNT  = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q;
  logic        we_q, reg_write_q, mem_to_reg_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;

  logic        access, fmt_ok, issue, timeout;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        req, stall, rw, misalign, bus_err;
  logic [31:0] rdata_sh;

  assign access  = mem_read_i | mem_write_i;
  assign timeout = (cnt_q == TIMEOUT_CNT);

  always_comb begin
    fmt_ok   = 1'b0;
    be_in    = 4'b1111;
    wdata_in = store_data_i;
    case (funct3_i)
      3'b000, 3'b100: fmt_ok = 1'b1;
      3'b001, 3'b101: fmt_ok = ~alu_res_i[0];
      3'b010:         fmt_ok = (alu_res_i[1:0] == 2'b00);
      default:        fmt_ok = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b00: begin
        be_in    = 4'b0001 << alu_res_i[1:0];
        wdata_in = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {alu_res_i[1], 1'b0};
        wdata_in = {2{store_data_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data_i;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    req          = 1'b0;
    stall        = 1'b0;
    rw           = 1'b0;
    misalign     = 1'b0;
    bus_err      = 1'b0;
    dmem_we_o    = we_q;
    dmem_addr_o  = {addr_q[31:2], 2'b00};
    dmem_be_o    = be_q;
    dmem_wdata_o = wdata_q;
    alu_res_o    = addr_q;
    rd_o         = rd_q;
    mem_to_reg_o = mem_to_reg_q;
    case (state_q)
      S_IDLE: begin
        dmem_we_o    = mem_write_i;
        dmem_addr_o  = {alu_res_i[31:2], 2'b00};
        dmem_be_o    = be_in;
        dmem_wdata_o = wdata_in;
        alu_res_o    = alu_res_i;
        rd_o         = rd_i;
        mem_to_reg_o = mem_to_reg_i;
        rw           = reg_write_i;
        if (access) begin
          if (!fmt_ok) begin
            misalign = 1'b1;
            rw       = 1'b0;
          end else begin
            req   = 1'b1;
            issue = 1'b1;
            if (!dmem_gnt_i) begin
              stall   = 1'b1;
              rw      = 1'b0;
              state_d = S_WAIT_GNT;
            end else if (!mem_write_i) begin
              stall   = 1'b1;
              rw      = 1'b0;
              state_d = S_WAIT_RDATA;
            end
          end
        end
      end
      S_WAIT_GNT: begin
        // An abort withdraws the request, so a grant cannot race the timeout.
        if (timeout) begin
          bus_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          req = 1'b1;
          if (!dmem_gnt_i) begin
            stall = 1'b1;
          end else if (we_q) begin
            rw      = reg_write_q;
            state_d = S_IDLE;
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT_RDATA;
          end
        end
      end
      S_WAIT_RDATA: begin
        if (dmem_rvalid_i) begin
          rw      = reg_write_q;
          state_d = S_IDLE;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_sh = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  read_data_o = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  read_data_o = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b100:  read_data_o = {24'd0, rdata_sh[7:0]};
      3'b101:  read_data_o = {16'd0, rdata_sh[15:0]};
      default: read_data_o = dmem_rdata_i;
    endcase
  end

  // Reset gates the control outputs directly because IDLE outputs are combinational.
  assign dmem_req_o  = req & ~rst;
  assign stall_o     = stall & ~rst;
  assign reg_write_o = rw & ~rst;
  assign misalign_o  = misalign & ~rst;
  assign bus_err_o   = bus_err & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q && state_d != S_IDLE)
        cnt_q <= 8'd0;
      else if (state_q != S_IDLE)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (issue) begin
      we_q         <= mem_write_i;
      addr_q       <= alu_res_i;
      be_q         <= be_in;
      wdata_q      <= wdata_in;
      funct3_q     <= funct3_i;
      rd_q         <= rd_i;
      reg_write_q  <= reg_write_i;
      mem_to_reg_q <= mem_to_reg_i;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized and directed bench for mem_stage_lsu; each access is predicted at
// transaction level from its grant/rvalid delays and checked cycle by cycle.
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, store_data_i;
  logic [4:0]  rd_i;
  logic        reg_write_i, mem_to_reg_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] read_data_o, alu_res_o;
  logic [4:0]  rd_o;
  logic        mem_to_reg_o, reg_write_o, stall_o, misalign_o, bus_err_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i),
    .rd_i(rd_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .read_data_o(read_data_o), .alu_res_o(alu_res_o), .rd_o(rd_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic go_idle();
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    funct3_i     = 3'($urandom);
    alu_res_i    = $urandom;
    store_data_i = $urandom;
    rd_i         = 5'($urandom);
    reg_write_i  = 1'($urandom);
    mem_to_reg_i = 1'($urandom);
    dmem_gnt_i   = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] s;
    s = w >> (int'(off) * 8);
    case (f3)
      3'b000:  return 32'($signed(s[7:0]));
      3'b001:  return 32'($signed(s[15:0]));
      3'b100:  return 32'(s[7:0]);
      3'b101:  return 32'(s[15:0]);
      default: return w;
    endcase
  endfunction

  // g: cycles of gnt=0 before the grant; r: cycles after the grant until rvalid.
  task automatic run_txn(input string tag, input bit ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int g,
                         input int r, input logic [31:0] rdw);
    logic [4:0]  rd;
    logic        regw, m2r, ok, tmo;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          last, req_last;
    rd   = 5'($urandom);
    regw = 1'($urandom);
    m2r  = 1'($urandom);
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = (a % 2 == 0);
      3'b010:         ok = (a % 4 == 0);
      default:        ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b00:   begin ebe = 4'(1 << a[1:0]); ewd = d[7:0] * 32'h01010101; end
      2'b01:   begin ebe = 4'(3 << a[1:0]); ewd = d[15:0] * 32'h00010001; end
      default: begin ebe = 4'hF; ewd = d; end
    endcase
    mem_read_i = ld; mem_write_i = !ld; funct3_i = f3; alu_res_i = a;
    store_data_i = d; rd_i = rd; reg_write_i = regw; mem_to_reg_i = m2r;
    dmem_rdata_i = rdw;
    if (!ok) begin
      dmem_gnt_i = 1'($urandom);
      @(negedge clk);
      chk({tag, "/misalign"}, 32'(misalign_o), 32'd1);
      chk({tag, "/mis_req"}, 32'(dmem_req_o), 32'd0);
      chk({tag, "/mis_stall"}, 32'(stall_o), 32'd0);
      chk({tag, "/mis_rw"}, 32'(reg_write_o), 32'd0);
      @(posedge clk); #1;
      go_idle();
      @(negedge clk);
      chk({tag, "/mis_pulse"}, 32'(misalign_o), 32'd0);
      chk({tag, "/mis_idle_stall"}, 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (g > TO) begin last = TO + 1; tmo = 1'b1; end
    else if (!ld) begin last = g; tmo = 1'b0; end
    else if (r <= TO + 1) begin last = g + r; tmo = 1'b0; end
    else begin last = g + 1 + TO; tmo = 1'b1; end
    req_last = (g < TO) ? g : TO;
    for (int k = 0; k <= last; k++) begin
      dmem_gnt_i = (k == g);
      dmem_rvalid_i = (ld && g <= TO && k > g) ? (k == g + r) : 1'($urandom);
      @(negedge clk);
      chk({tag, "/stall"}, 32'(stall_o), 32'(k != last));
      chk({tag, "/req"}, 32'(dmem_req_o), 32'(k <= req_last));
      chk({tag, "/rw"}, 32'(reg_write_o), 32'((k == last && !tmo) ? regw : 1'b0));
      chk({tag, "/bus_err"}, 32'(bus_err_o), 32'(k == last && tmo));
      if (k <= req_last) begin
        chk({tag, "/addr"}, dmem_addr_o, a & 32'hFFFF_FFFC);
        chk({tag, "/we"}, 32'(dmem_we_o), 32'(!ld));
        chk({tag, "/be"}, 32'(dmem_be_o), 32'(ebe));
        if (!ld) chk({tag, "/wdata"}, dmem_wdata_o, ewd);
      end
      if (k == last && !tmo) begin
        chk({tag, "/rd"}, 32'(rd_o), 32'(rd));
        chk({tag, "/alu_res"}, alu_res_o, a);
        chk({tag, "/m2r"}, 32'(mem_to_reg_o), 32'(m2r));
        if (ld) chk({tag, "/rdata"}, read_data_o, load_fmt(rdw, f3, a[1:0]));
      end
      @(posedge clk); #1;
      go_idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    go_idle();
    dmem_rdata_i = 32'd0;
    mem_read_i = 1'b1; funct3_i = 3'b010; alu_res_i = 32'h100;
    dmem_gnt_i = 1'b1;
    #12;
    chk("reset/req", 32'(dmem_req_o), 32'd0);
    chk("reset/stall", 32'(stall_o), 32'd0);
    chk("reset/rw", 32'(reg_write_o), 32'd0);
    chk("reset/misalign", 32'(misalign_o), 32'd0);
    chk("reset/bus_err", 32'(bus_err_o), 32'd0);
    go_idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_txn("sb_1003", 1'b0, 3'b000, 32'h1003, 32'h0000_00A5, 0, 1, 32'd0);
    run_txn("lh_2002", 1'b1, 3'b001, 32'h2002, 32'd0, 0, 2, 32'h8001_1234);
    run_txn("lw_0006", 1'b1, 3'b010, 32'h0006, 32'd0, 0, 1, 32'd0);
    run_txn("sw_gnt3", 1'b0, 3'b010, 32'h3008, 32'hDEAD_BEEF, 3, 1, 32'd0);
    run_txn("lw_tmo", 1'b1, 3'b010, 32'h0100, 32'd0, 0, 20, 32'h1111_2222);
    run_txn("sh_gnt_tmo", 1'b0, 3'b001, 32'h0202, 32'h1234_5678, 9, 1, 32'd0);
    run_txn("lbu_late", 1'b1, 3'b100, 32'h0401, 32'd0, 2, 5, 32'hCAFE_F00D);

    for (int i = 0; i < 6; i++) begin
      go_idle();
      dmem_rvalid_i = 1'($urandom);
      @(negedge clk);
      chk("pass/alu_res", alu_res_o, alu_res_i);
      chk("pass/rd", 32'(rd_o), 32'(rd_i));
      chk("pass/rw", 32'(reg_write_o), 32'(reg_write_i));
      chk("pass/m2r", 32'(mem_to_reg_o), 32'(mem_to_reg_i));
      chk("pass/stall", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
    end

    // Reset while a load waits for data.
    mem_read_i = 1'b1; funct3_i = 3'b010; alu_res_i = 32'h0800; dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    go_idle();
    chk("rst_mid/pre_stall", 32'(stall_o), 32'd1);
    rst = 1'b1; mem_read_i = 1'b1; dmem_gnt_i = 1'b1;
    #1;
    chk("rst_mid/req", 32'(dmem_req_o), 32'd0);
    chk("rst_mid/stall", 32'(stall_o), 32'd0);
    chk("rst_mid/rw", 32'(reg_write_o), 32'd0);
    go_idle();
    dmem_rvalid_i = 1'b1; reg_write_i = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_stale/stall", 32'(stall_o), 32'd0);
    chk("rst_stale/rw", 32'(reg_write_o), 32'd1);
    chk("rst_stale/req", 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    go_idle();

    for (int i = 0; i < 150; i++) begin
      run_txn($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 6)), int'($urandom_range(1, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
